// File: rtl/freq_meas.sv
// freq_meas: measures period and high time of a divided-clock signal in
// reference-clock cycles, flags lock once consecutive measurements agree,
// and flags timeout when rising edges stop arriving.
module freq_meas #(
  parameter int n        = 8,  // counter width; longest period is 2^n-1
  parameter int LOCK_CNT = 3   // matching measurements needed for lock (1..15)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [n-1:0] period,
  output logic [n-1:0] high,
  output logic         valid,
  output logic         lock,
  output logic         timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // Saturation value of the period counter; reaching it without an edge
  // means the input has stopped.
  localparam logic [n-1:0] CNT_MAX  = {n{1'b1}};
  localparam logic [n-1:0] CNT_ONE  = {{(n-1){1'b0}}, 1'b1};
  localparam logic [3:0]   LOCK_RUN = 4'(LOCK_CNT);

  state_t       state_reg, state_next;
  logic         s0, s1;
  logic         rise;
  logic [n-1:0] per_cnt, per_cnt_next;
  logic [n-1:0] hi_cnt, hi_cnt_next;
  logic [3:0]   run, run_next;
  logic [n-1:0] period_next, high_next;
  logic         valid_next, lock_next, timeout_next;
  logic         same_pair;

  // Two-flop input stage: synchronizes sig_in and provides the previous
  // sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= sig_in;
      s1 <= s0;
    end
  end

  assign rise = s0 & ~s1;

  // A new measurement repeats the previous one only if both numbers match
  // and a run is already in progress (run is 0 after reset or timeout).
  assign same_pair = (per_cnt == period) && (hi_cnt == high) && (run != 4'd0);

  // State and measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      run       <= 4'd0;
      period    <= '0;
      high      <= '0;
      valid     <= 1'b0;
      lock      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_reg <= state_next;
      per_cnt   <= per_cnt_next;
      hi_cnt    <= hi_cnt_next;
      run       <= run_next;
      period    <= period_next;
      high      <= high_next;
      valid     <= valid_next;
      lock      <= lock_next;
      timeout   <= timeout_next;
    end
  end

  // Next-state and measurement logic; everything holds unless updated,
  // except valid which is a single-cycle pulse.
  always_comb begin
    state_next   = state_reg;
    per_cnt_next = per_cnt;
    hi_cnt_next  = hi_cnt;
    run_next     = run;
    period_next  = period;
    high_next    = high;
    valid_next   = 1'b0;
    lock_next    = lock;
    timeout_next = timeout;

    case (state_reg)
      IDLE: begin
        // The first edge only opens a measurement window; it cannot report
        // anything and it leaves a pending timeout flag untouched.
        per_cnt_next = '0;
        if (rise) begin
          state_next   = MEAS;
          per_cnt_next = CNT_ONE;
          hi_cnt_next  = CNT_ONE;
        end
      end

      MEAS: begin
        if (rise) begin
          // Close the current window and open the next one on the same edge.
          // An edge arriving exactly at saturation still counts as a valid
          // measurement of the longest period.
          period_next  = per_cnt;
          high_next    = hi_cnt;
          valid_next   = 1'b1;
          per_cnt_next = CNT_ONE;
          hi_cnt_next  = CNT_ONE;
          timeout_next = 1'b0;
          if (same_pair) begin
            run_next = (run >= LOCK_RUN) ? LOCK_RUN : run + 4'd1;
          end else begin
            run_next = 4'd1;
          end
          lock_next = (run_next >= LOCK_RUN);
        end else if (per_cnt == CNT_MAX) begin
          // No edge within the longest measurable period: give up, drop lock
          // and keep the last good measurement on the outputs.
          state_next   = IDLE;
          per_cnt_next = '0;
          timeout_next = 1'b1;
          run_next     = 4'd0;
          lock_next    = 1'b0;
        end else begin
          // hi_cnt only grows when per_cnt does, so high never exceeds period.
          per_cnt_next = per_cnt + CNT_ONE;
          hi_cnt_next  = hi_cnt + {{(n-1){1'b0}}, s0};
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_freq_meas.sv
// Testbench for freq_meas: drives sampled waveforms, predicts results from
// the history of posedge samples, and checks every cycle.
module tb_freq_meas;

  localparam int N     = 8;
  localparam int LOCK  = 3;
  localparam int MAXC  = 255;
  localparam int HSIZE = 16384;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic [N-1:0] period, high;
  logic         valid, lock, timeout;

  int checks = 0;
  int errors = 0;

  freq_meas #(.n(N), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high(high), .valid(valid), .lock(lock), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: history of posedge samples since reset, plus the index of
  // the edge that handled the last rise. A measurement is the distance between
  // handled rises and the number of high samples in between.
  bit         hist [0:HSIZE-1];
  int         e;
  int         last_h;
  bit         m_active;
  int         m_run;
  logic       m_valid, m_lock, m_timeout;
  logic [7:0] m_period, m_high;
  bit         pat [$];

  function automatic bit hs(input int i);
    if (i < 1 || i >= HSIZE) return 1'b0;
    return hist[i];
  endfunction

  task automatic model_reset();
    e = 0; last_h = 0; m_active = 0; m_run = 0;
    m_valid = 0; m_lock = 0; m_timeout = 0; m_period = '0; m_high = '0;
    for (int i = 0; i < HSIZE; i++) hist[i] = 1'b0;
  endtask

  task automatic model_update(input bit v);
    bit rise_seen;
    int p, h;
    e++;
    if (e < HSIZE) hist[e] = v;
    rise_seen = hs(e-1) && !hs(e-2);
    m_valid = 1'b0;
    if (m_active) begin
      if (rise_seen) begin
        p = e - last_h;
        h = 0;
        for (int i = last_h - 1; i <= e - 2; i++) h += int'(hs(i));
        if (p == int'(m_period) && h == int'(m_high) && m_run > 0)
          m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
        else
          m_run = 1;
        m_valid = 1'b1; m_period = 8'(p); m_high = 8'(h);
        m_lock = (m_run >= LOCK); m_timeout = 1'b0;
        last_h = e;
      end else if (e - last_h == MAXC) begin
        m_timeout = 1'b1; m_active = 0; m_run = 0; m_lock = 1'b0;
      end
    end else if (rise_seen) begin
      m_active = 1; last_h = e;
    end
  endtask

  // One clock: drive v before the posedge, optionally change to mid shortly
  // after it (between sampling edges), and return at the next negedge.
  task automatic step(input bit v, input bit mid);
    sig_in = v;
    @(posedge clk);
    model_update(v);
    #1 sig_in = mid;
    @(negedge clk);
  endtask

  task automatic add_div(input int nn, input int hh, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < nn; i++) pat.push_back(i < hh);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    if ({valid, lock, timeout, period, high} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got v%b l%b t%b p%0d h%0d, want all 0", valid, lock, timeout, period, high);
    end
    checks++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      if ({valid, lock, timeout, period, high} !== 19'd0) begin
        errors++;
        $display("FAIL reset_idle_low cyc %0d: got v%b l%b t%b p%0d h%0d, want all 0", e, valid, lock, timeout, period, high);
      end
      checks++;
    end
  endtask

  task automatic test_div2();
    int vcnt, last_v;
    vcnt = 0; last_v = 0;
    pat.delete();
    add_div(2, 1, 12);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL div2 cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid) begin
        vcnt++;
        if (vcnt > 1) begin
          if (e - last_v != 2) begin
            errors++;
            $display("FAIL div2_spacing: got %0d cycles, want 2", e - last_v);
          end
          checks++;
        end
        last_v = e;
        if (vcnt == 3) begin
          if ({lock, period, high} !== {1'b1, 8'd2, 8'd1}) begin
            errors++;
            $display("FAIL div2_lock3: got l%b p%0d h%0d, want l1 p2 h1", lock, period, high);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_div4();
    int v4;
    v4 = 0;
    pat.delete();
    add_div(4, 2, 8);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL div4 cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid && period == 8'd4) begin
        v4++;
        if (lock !== (v4 >= 3) || high !== 8'd2) begin
          errors++;
          $display("FAIL div4_lock valid#%0d: got l%b h%0d, want l%b h2", v4, lock, high, (v4 >= 3));
        end
        checks++;
      end
    end
  endtask

  task automatic test_div3();
    int vc;
    logic [7:0] h_first;
    pat.delete();
    add_div(3, 1, 8);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL div3_pos cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
    end
    if ({lock, period, high} !== {1'b1, 8'd3, 8'd1}) begin
      errors++;
      $display("FAIL div3_pos_end: got l%b p%0d h%0d, want l1 p3 h1", lock, period, high);
    end
    checks++;
    // Negedge-generated 50% div3: 1.5 cycles high, 1.5 low, in half cycles.
    vc = 0; h_first = '0;
    for (int j = 0; j < 24; j++) begin
      step(((2*j) % 6) < 3, ((2*j+1) % 6) < 3);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL div3_neg cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid) begin
        vc++;
        if (vc == 2) h_first = high;
        if (vc >= 2) begin
          if (period !== 8'd3 || high !== h_first || high < 8'd1 || high > 8'd2) begin
            errors++;
            $display("FAIL div3_neg_meas: got p%0d h%0d, want p3 h%0d (1 or 2)", period, high, h_first);
          end
          checks++;
        end
      end
    end
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL div3_neg_lock: got %b, want 1", lock);
    end
    checks++;
  endtask

  task automatic test_div4_to_div6();
    int v6;
    v6 = 0;
    pat.delete();
    add_div(4, 2, 6);
    add_div(6, 3, 6);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL div4to6 cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (i == 23) begin
        if (lock !== 1'b1) begin
          errors++;
          $display("FAIL div4to6_pre_lock: got %b, want 1", lock);
        end
        checks++;
      end
      if (valid && period == 8'd6 && high == 8'd3) begin
        v6++;
        if (v6 <= 3 && lock !== (v6 == 3)) begin
          errors++;
          $display("FAIL div4to6_lock valid#%0d: got %b, want %b", v6, lock, (v6 == 3));
        end
        if (v6 <= 3) checks++;
      end
    end
  endtask

  task automatic test_timeout();
    int last_v, t_at, vc;
    bit prev_to;
    last_v = 0; t_at = -1;
    pat.delete();
    add_div(4, 2, 6);
    for (int i = 0; i < 300; i++) pat.push_back(1'b0);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL timeout cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid) last_v = e;
      if (timeout && t_at < 0) begin
        t_at = e;
        if (e - last_v != 255 || lock !== 1'b0 || period !== 8'd4) begin
          errors++;
          $display("FAIL timeout_assert: got delay %0d l%b p%0d, want delay 255 l0 p4", e - last_v, lock, period);
        end
        checks++;
      end
    end
    if (t_at < 0) begin
      errors++;
      $display("FAIL timeout_missing: got no timeout within 300 cycles, want one");
      checks++;
    end
    pat.delete();
    add_div(4, 2, 3);
    vc = 0; prev_to = timeout;
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL restart cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid) begin
        vc++;
        if (vc == 1 && (prev_to !== 1'b1 || timeout !== 1'b0)) begin
          errors++;
          $display("FAIL restart_clear: got timeout before/after %b/%b, want 1/0", prev_to, timeout);
        end
        if (vc == 1) checks++;
      end
      prev_to = timeout;
    end
    if (vc != 2) begin
      errors++;
      $display("FAIL restart_valids: got %0d, want 2", vc);
    end
    checks++;
  endtask

  task automatic test_mid_reset();
    int vc;
    pat.delete();
    add_div(7, 3, 5);
    pat.push_back(1'b1);
    pat.push_back(1'b1);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL div7 cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
    end
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL div7_locked: got %b, want 1", lock);
    end
    checks++;
    // Reset lands between clock edges; outputs must clear without a clock.
    #2 rst = 1'b1;
    #1;
    if ({valid, lock, timeout, period, high} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got v%b l%b t%b p%0d h%0d, want all 0", valid, lock, timeout, period, high);
    end
    checks++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pat.delete();
    add_div(7, 3, 4);
    vc = 0;
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL post_reset cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid) begin
        vc++;
        if (vc == 1 && (e != 9 || period !== 8'd7 || high !== 8'd3)) begin
          errors++;
          $display("FAIL post_reset_first: got cyc %0d p%0d h%0d, want cyc 9 p7 h3", e, period, high);
        end
        if (vc == 1) checks++;
      end
    end
  endtask

  task automatic test_random();
    int nn, gap;
    pat.delete();
    for (int s = 0; s < 6; s++) begin
      nn = $urandom_range(20, 2);
      add_div(nn, $urandom_range(nn - 1, 1), $urandom_range(6, 3));
    end
    for (int i = 0; i < 40; i++) pat.push_back($urandom_range(1, 0) == 1);
    gap = $urandom_range(300, 200);
    for (int i = 0; i < gap; i++) pat.push_back(1'b0);
    add_div(5, 2, 4);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL random cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
    end
  endtask

  task automatic test_max_period();
    int v255;
    bit saw_to;
    v255 = 0; saw_to = 0;
    pulse_rst();
    pat.delete();
    add_div(255, 1, 4);
    for (int i = 0; i < 5; i++) pat.push_back(1'b0);
    foreach (pat[i]) begin
      step(pat[i], pat[i]);
      if ({valid, lock, timeout, period, high} !== {m_valid, m_lock, m_timeout, m_period, m_high}) begin
        errors++;
        $display("FAIL maxper cyc %0d: dut v%b l%b t%b p%0d h%0d, model v%b l%b t%b p%0d h%0d", e, valid, lock, timeout, period, high, m_valid, m_lock, m_timeout, m_period, m_high);
      end
      checks++;
      if (valid && period == 8'd255 && high == 8'd1) v255++;
      if (i < 1020 && timeout) saw_to = 1;
    end
    if (v255 != 3 || saw_to) begin
      errors++;
      $display("FAIL maxper_valid: got %0d valids of 255 timeout_seen=%b, want 3 and 0", v255, saw_to);
    end
    checks++;
    if (timeout !== 1'b1 || period !== 8'd255 || lock !== 1'b0) begin
      errors++;
      $display("FAIL maxper_timeout: got t%b p%0d l%b, want t1 p255 l0", timeout, period, lock);
    end
    checks++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_div2();
    test_div4();
    test_div3();
    test_div4_to_div6();
    test_timeout();
    test_mid_reset();
    test_random();
    test_max_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
